// File: rtl/ahb_burst_slave.sv
// AHB-Lite burst-capable memory slave with protocol and address checking.
// Latency: a good transfer takes WAIT_STATES low cycles, then completes. A bad transfer gets a two-cycle ERROR.
// Backpressure: HREADYOUT is held low during wait states and ERR1. Address phases are accepted only while HREADYOUT is high.
// Ports: HCLK/HRESETn are the clock and the async active-low reset.
//        HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HREADY form the address phase. HWDATA carries write data.
//        HREADYOUT/HRESP/HRDATA form the data-phase response.
module ahb_burst_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int BSH = $clog2(NB);
  localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;

  // Pending good data phase.
  logic                   dph_vld_q;
  logic                   dph_wr_q;
  logic [2:0]             dph_size_q;
  logic [IW-1:0]          dph_idx_q;
  logic [BSH-1:0]         dph_off_q;

  // Burst tracking: attributes of the NONSEQ beat and the address of the last good beat.
  logic                   bst_vld_q;
  logic [ADDR_WIDTH-1:0]  bst_addr_q;
  logic [2:0]             bst_size_q;
  logic [2:0]             bst_burst_q;
  logic                   bst_wr_q;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic                   acc, bad, seq_bad, rng_bad, size_bad, align_bad;
  logic [ADDR_WIDTH-1:0]  word_idx, inc, wmask, exp_addr;
  logic                   dph_done, wr_en, rd_en;
  logic [NB-1:0]          be;

  assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign acc       = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  // Address-phase checks.
  always_comb begin
    word_idx = HADDR >> BSH;
    inc      = ADDR_WIDTH'(1) << HSIZE;
    // An all-ones mask turns the wrap formula into a plain increment for INCR types.
    case (bst_burst_q)
      3'b010:  wmask = (inc << 2) - 1'b1;
      3'b100:  wmask = (inc << 3) - 1'b1;
      3'b110:  wmask = (inc << 4) - 1'b1;
      default: wmask = '1;
    endcase
    exp_addr  = (bst_addr_q & ~wmask) | ((bst_addr_q + inc) & wmask);
    size_bad  = HSIZE > 3'(BSH);
    align_bad = (HADDR & (inc - 1'b1)) != '0;
    rng_bad   = word_idx >= ADDR_WIDTH'(MEM_DEPTH);
    seq_bad   = (HTRANS == TR_SEQ) &&
                (!bst_vld_q || (HSIZE != bst_size_q) || (HBURST != bst_burst_q) ||
                 (HWRITE != bst_wr_q) || (HADDR != exp_addr));
    bad       = size_bad || align_bad || rng_bad || seq_bad;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (acc) begin
          if (bad) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      // The wait count advances regardless of HREADY/HTRANS: this is our own data phase.
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dph_done = dph_vld_q && (state_q == ST_IDLE);
  assign wr_en    = dph_done && dph_wr_q;
  assign rd_en    = dph_done && !dph_wr_q;

  // A write completes at the edge closing its data phase, so a read in the very next data phase sees it.
  assign HRDATA = rd_en ? mem[dph_idx_q] : rdata_q;

  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++)
      be[b] = (b >= int'(dph_off_q)) && (b < int'(dph_off_q) + (1 << dph_size_q));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dph_vld_q   <= 1'b0;
      dph_wr_q    <= 1'b0;
      dph_size_q  <= '0;
      dph_idx_q   <= '0;
      dph_off_q   <= '0;
      bst_vld_q   <= 1'b0;
      bst_addr_q  <= '0;
      bst_size_q  <= '0;
      bst_burst_q <= '0;
      bst_wr_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc && !bad) begin
        dph_vld_q  <= 1'b1;
        dph_wr_q   <= HWRITE;
        dph_size_q <= HSIZE;
        dph_idx_q  <= HADDR[BSH +: IW];
        dph_off_q  <= HADDR[BSH-1:0];
      end else if (dph_done) begin
        dph_vld_q  <= 1'b0;
      end
      if (acc) begin
        if (bad) begin
          bst_vld_q <= 1'b0;
        end else begin
          bst_addr_q <= HADDR;
          if (HTRANS == TR_NONSEQ) begin
            bst_vld_q   <= 1'b1;
            bst_size_q  <= HSIZE;
            bst_burst_q <= HBURST;
            bst_wr_q    <= HWRITE;
          end
        end
      end
      if (rd_en) rdata_q <= mem[dph_idx_q];
    end
  end

  // Storage is deliberately not reset. wr_en is low throughout reset, so an interrupted write is dropped.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[dph_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_ahb_burst_slave.sv
module tb_ahb_burst_slave;
  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
  localparam logic [2:0] SZB = 3'd0, SZH = 3'd1, SZW = 3'd2, SZD = 3'd3;
  localparam logic [2:0] SGL = 3'd0, INC = 3'd1, WR4 = 3'd2, IN4 = 3'd3;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hrdyo0, hrdyo2, hresp0, hresp2;
  logic [31:0] hrdata0, hrdata2;

  int n_cmp = 0;
  int n_bad = 0;

  assign hready = hrdyo0 & hrdyo2;
  always #5 hclk = ~hclk;

  ahb_burst_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hrdyo0), .HRESP(hresp0), .HRDATA(hrdata0));

  ahb_burst_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hrdyo2), .HRESP(hresp2), .HRDATA(hrdata2));

  typedef struct {
    string       name;
    bit          dut;       // 0: zero-wait slave, 1: two-wait slave
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic [1:0]  gap;       // HTRANS driven during this transfer's data phase
    int          exp_lows;
    bit          exp_lresp;
    bit          exp_resp;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input string nm, input bit d, input logic [1:0] tr, input bit wr,
                              input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu,
                              input logic [31:0] wd, input logic [1:0] gp, input bit err,
                              input bit chk, input logic [31:0] erd);
    vec_t t;
    t.name = nm; t.dut = d; t.trans = tr; t.wr = wr; t.addr = a; t.size = sz; t.burst = bu;
    t.wdata = wd; t.gap = gp;
    t.exp_lows  = err ? 1 : (d ? 2 : 0);
    t.exp_lresp = err;
    t.exp_resp  = err;
    t.chk_rd = chk; t.exp_rd = erd;
    vt.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transfer, entered at posedge+1 with the bus idle; returns at posedge+1 after completion.
  task automatic run_xfer(input vec_t t, output int lows, output bit lresp, output bit resp,
                          output logic [31:0] rd);
    int cyc;
    hsel0 = !t.dut; hsel2 = t.dut;
    htrans = t.trans; hwrite = t.wr; haddr = t.addr; hsize = t.size; hburst = t.burst;
    lows = 0; lresp = 1'b0; resp = 1'b0; rd = '0; cyc = 0;
    @(posedge hclk); #1;
    htrans = t.gap; hwdata = t.wdata;
    forever begin
      @(negedge hclk);
      if (t.dut ? hrdyo2 : hrdyo0) begin
        resp = t.dut ? hresp2 : hresp0;
        rd   = t.dut ? hrdata2 : hrdata0;
        break;
      end
      lows++;
      lresp |= (t.dut ? hresp2 : hresp0);
      cyc++;
      if (cyc > 20) begin
        lows = -1;
        break;
      end
      @(posedge hclk); #1;
    end
    @(posedge hclk); #1;
  endtask

  task automatic do_vec(input vec_t t);
    int lows; bit lresp, resp; logic [31:0] rd;
    run_xfer(t, lows, lresp, resp, rd);
    chk({t.name, "/low_cycles"}, 32'(lows), 32'(t.exp_lows));
    chk({t.name, "/resp_low"}, {31'b0, lresp}, {31'b0, t.exp_lresp});
    chk({t.name, "/resp"}, {31'b0, resp}, {31'b0, t.exp_resp});
    if (t.chk_rd) chk({t.name, "/rdata"}, rd, t.exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    hresetn = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; haddr = '0; htrans = TI; hwrite = 1'b0;
    hsize = SZW; hburst = SGL; hwdata = '0;

    //   name         dut tr  wr addr        size burst wdata         gap err chk exp_rd
    add("w_10",        0, TN, 1, 32'h10,    SZW, SGL, 32'hDEADBEEF, TI, 0, 0, 32'h0);
    add("r_10",        0, TN, 0, 32'h10,    SZW, SGL, 32'h0,        TI, 0, 1, 32'hDEADBEEF);
    add("w_40",        0, TN, 1, 32'h40,    SZW, SGL, 32'h11223344, TI, 0, 0, 32'h0);
    add("wb_41",       0, TN, 1, 32'h41,    SZB, SGL, 32'h5555AA55, TI, 0, 0, 32'h0);
    add("r_40a",       0, TN, 0, 32'h40,    SZW, SGL, 32'h0,        TI, 0, 1, 32'h1122AA44);
    add("wh_42",       0, TN, 1, 32'h42,    SZH, SGL, 32'hBEEF1234, TI, 0, 0, 32'h0);
    add("r_40b",       0, TN, 0, 32'h40,    SZW, SGL, 32'h0,        TI, 0, 1, 32'hBEEFAA44);
    add("w_oob",       0, TN, 1, 32'h1000,  SZW, SGL, 32'h0,        TI, 1, 0, 32'h0);
    add("w_dword",     0, TN, 1, 32'h10,    SZD, SGL, 32'h0,        TI, 1, 0, 32'h0);
    add("w_misalign",  0, TN, 1, 32'h12,    SZW, SGL, 32'h0,        TI, 1, 0, 32'h0);
    add("r_10_kept",   0, TN, 0, 32'h10,    SZW, SGL, 32'h0,        TI, 0, 1, 32'hDEADBEEF);
    add("w_top",       0, TN, 1, 32'hFFC,   SZW, SGL, 32'hCAFEF00D, TI, 0, 0, 32'h0);
    add("r_top",       0, TN, 0, 32'hFFC,   SZW, SGL, 32'h0,        TI, 0, 1, 32'hCAFEF00D);
    add("i4w_30",      0, TN, 1, 32'h30,    SZW, IN4, 32'hA0A0A0A0, TB, 0, 0, 32'h0);
    add("i4w_34",      0, TS, 1, 32'h34,    SZW, IN4, 32'hA1A1A1A1, TB, 0, 0, 32'h0);
    add("i4w_38",      0, TS, 1, 32'h38,    SZW, IN4, 32'hA2A2A2A2, TB, 0, 0, 32'h0);
    add("i4w_3c",      0, TS, 1, 32'h3C,    SZW, IN4, 32'hA3A3A3A3, TI, 0, 0, 32'h0);
    add("w4r_38",      0, TN, 0, 32'h38,    SZW, WR4, 32'h0,        TB, 0, 1, 32'hA2A2A2A2);
    add("w4r_3c",      0, TS, 0, 32'h3C,    SZW, WR4, 32'h0,        TB, 0, 1, 32'hA3A3A3A3);
    add("w4r_30",      0, TS, 0, 32'h30,    SZW, WR4, 32'h0,        TB, 0, 1, 32'hA0A0A0A0);
    add("w4r_34",      0, TS, 0, 32'h34,    SZW, WR4, 32'h0,        TI, 0, 1, 32'hA1A1A1A1);
    add("w4x_38",      0, TN, 0, 32'h38,    SZW, WR4, 32'h0,        TB, 0, 1, 32'hA2A2A2A2);
    add("w4x_3c",      0, TS, 0, 32'h3C,    SZW, WR4, 32'h0,        TB, 0, 1, 32'hA3A3A3A3);
    add("w4x_40_bad",  0, TS, 0, 32'h40,    SZW, WR4, 32'h0,        TI, 1, 0, 32'h0);
    add("seq_no_bst",  0, TS, 0, 32'h44,    SZW, INC, 32'h0,        TI, 1, 0, 32'h0);
    add("w_50",        0, TN, 1, 32'h50,    SZW, INC, 32'h50505050, TB, 0, 0, 32'h0);
    add("seq_size",    0, TS, 1, 32'h52,    SZH, INC, 32'hFFFFFFFF, TI, 1, 0, 32'h0);
    add("r_50",        0, TN, 0, 32'h50,    SZW, SGL, 32'h0,        TI, 0, 1, 32'h50505050);
    add("ws2_w20",     1, TN, 1, 32'h20,    SZW, IN4, 32'hC0C0C0C0, TB, 0, 0, 32'h0);
    add("ws2_w24",     1, TS, 1, 32'h24,    SZW, IN4, 32'hC1C1C1C1, TB, 0, 0, 32'h0);
    add("ws2_w28",     1, TS, 1, 32'h28,    SZW, IN4, 32'hC2C2C2C2, TB, 0, 0, 32'h0);
    add("ws2_w2c",     1, TS, 1, 32'h2C,    SZW, IN4, 32'hC3C3C3C3, TI, 0, 0, 32'h0);
    add("ws2_r20",     1, TN, 0, 32'h20,    SZW, IN4, 32'h0,        TB, 0, 1, 32'hC0C0C0C0);
    add("ws2_r24",     1, TS, 0, 32'h24,    SZW, IN4, 32'h0,        TB, 0, 1, 32'hC1C1C1C1);
    add("ws2_r28",     1, TS, 0, 32'h28,    SZW, IN4, 32'h0,        TB, 0, 1, 32'hC2C2C2C2);
    add("ws2_r2c",     1, TS, 0, 32'h2C,    SZW, IN4, 32'h0,        TI, 0, 1, 32'hC3C3C3C3);
    add("ws2_w70",     1, TN, 1, 32'h70,    SZW, SGL, 32'h11111111, TI, 0, 0, 32'h0);
    add("ws2_oob",     1, TN, 1, 32'h2000,  SZW, SGL, 32'h0,        TI, 1, 0, 32'h0);

    // Reset state.
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_rdy0", {31'b0, hrdyo0}, 32'd1);
    chk("rst_rdy2", {31'b0, hrdyo2}, 32'd1);
    chk("rst_resp0", {31'b0, hresp0}, 32'd0);
    chk("rst_resp2", {31'b0, hresp2}, 32'd0);
    chk("rst_rdata0", hrdata0, 32'h0);
    chk("rst_rdata2", hrdata2, 32'h0);
    hresetn = 1'b1;

    for (int i = 0; i < vt.size(); i++) do_vec(vt[i]);

    // Pipelined write then read of the same word: the read must see the new data.
    hsel0 = 1'b1; hsel2 = 1'b0;
    htrans = TN; hwrite = 1'b1; haddr = 32'h60; hsize = SZW; hburst = SGL;
    @(posedge hclk); #1;
    hwdata = 32'h600DF00D; htrans = TN; hwrite = 1'b0; haddr = 32'h60;
    @(negedge hclk);
    chk("raw_wr_rdy", {31'b0, hrdyo0}, 32'd1);
    @(posedge hclk); #1;
    htrans = TI; hwdata = 32'h0;
    @(negedge hclk);
    chk("raw_rd_rdy", {31'b0, hrdyo0}, 32'd1);
    chk("raw_rdata", hrdata0, 32'h600DF00D);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("rdata_hold", hrdata0, 32'h600DF00D);
    @(posedge hclk); #1;

    // Reset asserted during the wait states of a write; old data must survive.
    hsel0 = 1'b0; hsel2 = 1'b1;
    htrans = TN; hwrite = 1'b1; haddr = 32'h70; hsize = SZW; hburst = SGL;
    @(posedge hclk); #1;
    htrans = TI; hwdata = 32'h22222222;
    @(negedge hclk);
    chk("rstw_in_wait", {31'b0, hrdyo2}, 32'd0);
    #1 hresetn = 1'b0;
    #1;
    chk("rstw_rdy", {31'b0, hrdyo2}, 32'd1);
    chk("rstw_resp", {31'b0, hresp2}, 32'd0);
    chk("rstw_rdata", hrdata2, 32'h0);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    t = '{name: "rstw_read70", dut: 1'b1, trans: TN, wr: 1'b0, addr: 32'h70, size: SZW,
          burst: SGL, wdata: 32'h0, gap: TI, exp_lows: 2, exp_lresp: 1'b0, exp_resp: 1'b0,
          chk_rd: 1'b1, exp_rd: 32'h11111111};
    do_vec(t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
